// File: rtl/lpf_decimator_if.sv
// Sample stream interface for lpf_decimator: FIR-side input and consumer-side
// valid/ready FIFO output, plus FIFO status.
interface lpf_decimator_if #(
  parameter int N  = 16,
  parameter int AW = 3
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [AW:0]  fill;
  logic         overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, fill, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, fill, overflow
  );
endinterface

// File: rtl/lpf_decimator.sv
// Decimate-by-2**DSHIFT output stage with a show-ahead FIFO and sticky overflow.
// Define LPF_DECIM_AVG_EN to push the truncated group mean instead of the last sample.
module lpf_decimator #(
  parameter int N      = 16,
  parameter int DSHIFT = 2,   // legal range 1..4
  parameter int AW     = 3
) (
  input  logic           clk,
  input  logic           reset,
  lpf_decimator_if.slave bus
);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

  logic [DSHIFT-1:0] phase_q, phase_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic [N-1:0]      mem_q [DEPTH];
  logic [N-1:0]      mem_d [DEPTH];

  logic         group_end;
  logic         pop;
  logic         push_ok;
  logic [N-1:0] push_val;

`ifdef LPF_DECIM_AVG_EN
  logic [N+DSHIFT-1:0] acc_q, acc_d;
  logic [N+DSHIFT-1:0] sum;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    group_end = bus.in_valid && (phase_q == '1);
    pop       = (fill_q != '0) && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = group_end && ((fill_q != FULL) || pop);

`ifdef LPF_DECIM_AVG_EN
    sum      = acc_q + {{DSHIFT{1'b0}}, bus.in_data};
    push_val = N'(sum >> DSHIFT);
    acc_d    = acc_q;
    if (bus.in_valid) acc_d = group_end ? '0 : sum;
`else
    push_val = bus.in_data;
`endif

    if (bus.in_valid) phase_d = phase_q + DSHIFT'(1);

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_val;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (group_end && !push_ok) overflow_d = 1'b1;

    unique case ({push_ok, pop})
      2'b10:   fill_d = fill_q + (AW + 1)'(1);
      2'b01:   fill_d = fill_q - (AW + 1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      // NOTE: FIFO storage is reset too, so out_data reads 0 out of reset
      // instead of X; costs a reset per entry, acceptable at this depth.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef LPF_DECIM_AVG_EN
      acc_q      <= '0;
`endif
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef LPF_DECIM_AVG_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (fill_q != '0);
  assign bus.fill      = fill_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/lpf_decimator.md
# lpf_decimator

Output stage placed directly downstream of the parameterized low-pass FIR. Takes one filtered sample per `in_valid` cycle, decimates by `2**DSHIFT` and, optionally, averages each group of samples. Decimated samples are buffered in a small FIFO. The FIFO is drained by the downstream consumer through a valid/ready handshake. A sticky flag reports any sample lost to FIFO overflow.

## Interface
Parameters:
- `N`, 16, sample width in bits (unsigned, matches FIR output width)
- `DSHIFT`, 2, log2 of decimation factor; `DECIM = 2**DSHIFT`; legal range 1..4
- `AW`, 3, FIFO address width; `DEPTH = 2**AW` entries

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `in_data`  in  N  filtered sample from FIR stage
- `in_valid`  in  1  `in_data` is valid this cycle; no backpressure to upstream
- `out_data`  out  N  FIFO head sample
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head this cycle
- `fill`  out  AW+1  current FIFO occupancy, 0..DEPTH
- `overflow`  out  1  sticky; set when a decimated sample is dropped

## Operation
- **Phase counter:** `phase` is DSHIFT bits wide.
  - It advances only on cycles with `in_valid=1`, wrapping from DECIM-1 to 0.
  - Idle cycles do not affect it.
- **Group end:** a group completes on an `in_valid` cycle with `phase==DECIM-1`. This produces one push request.
- **Accumulator:** `acc` is N+DSHIFT bits, unsigned, with no overflow possible.
  - On `in_valid` with `phase!=DECIM-1`: `acc <= acc + in_data`.
  - On group end: `acc <= 0`.
- **Pushed value:**
  - With averaging: `(acc + in_data) >> DSHIFT`, i.e. bits [N+DSHIFT-1:DSHIFT], truncating.
  - Without averaging: `in_data` of the group-end cycle.
- **FIFO:** DEPTH entries, write pointer, read pointer, and `fill` counter.
  - Push is accepted if `fill<DEPTH`, or if a pop occurs in the same cycle.
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle leave `fill` unchanged. Pointers wrap modulo DEPTH.
- **Full:** if a push request meets `fill==DEPTH` with no pop, the sample is discarded, pointers and `fill` are unchanged, and `overflow <= 1`.
  - `overflow` clears only on `reset`.
- **Empty:** `out_ready` is ignored and pointers are unchanged.
- **Read port:** `out_data` is a combinational read of the entry at the read pointer (show-ahead). It is meaningful only while `out_valid=1`.
- **Reset:**
  - Clears `phase`, `acc`, both pointers, `fill`, `overflow`, and every FIFO entry.
  - A partial group in progress is discarded.
  - Reset overrides a simultaneous push or pop.

## Timing
- Reset values: `out_valid=0`, `fill=0`, `overflow=0`, `out_data=0`.
- **Push latency:** group end in cycle t has the following effects:
  - The entry is written at the rising edge ending cycle t.
  - `fill` increments and, if the FIFO was empty, `out_valid=1` and `out_data` shows the value in cycle t+1.
- **Pop:** a handshake in cycle t advances the read pointer at the edge. The next entry, or `out_valid=0` if the FIFO was emptied, appears in cycle t+1.
- `overflow` rises in the cycle after the dropped push.
- **Throughput:**
  - Input accepts one sample per cycle.
  - Output sustains one pop per cycle.
  - The sustained push rate is 1/DECIM.
- `fill` and `out_valid` are registered-equivalent: they change only at clock edges.

## Configuration
- Macro `LPF_DECIM_AVG_EN`:
  - **Defined:** the pushed value is the truncated mean of the DECIM samples in the group, and the accumulator is instantiated.
  - **Undefined:** pure decimation. The pushed value is the last sample of each group, the accumulator is removed, and the phase counter and FIFO behave identically.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid=1`, then release.
  - Required: `out_valid=0`, `fill=0`, `overflow=0` and `out_data=0` during and after reset, until the first group end.
- **Averaging:** DSHIFT=2, `LPF_DECIM_AVG_EN`, back-to-back input 10, 20, 30, 41.
  - Required: `out_data=25` with `out_valid=1` the cycle after 41.
  - Without the macro: `out_data=41`.
- **Gapped input:** samples 4, 4, 4, 4 with 3 idle cycles between each.
  - Required: exactly one output, value 4.
  - `phase` is unchanged across idle cycles.
- **Overflow:** `out_ready=0`, feed 9 groups of constant values 1..9.
  - Required: `fill=8` and `overflow=1` after the 9th group; value 9 is lost.
  - Then `out_ready=1`: pops 1..8 in order, then `out_valid=0`, `overflow` still 1.
- **Full with simultaneous pop:** FIFO at `fill=8`, group end coincides with `out_ready=1`.
  - Required: `fill` stays 8, `overflow` stays 0, and the new value lands at the tail.
- **Reset mid-group:** feed 2 samples of 500, assert `reset` 1 cycle, then feed 4 samples of 100.
  - Required: exactly one output, value 100; the partial 500 group produces no output.
